// File: rtl/alu_ctrl_seq_if.sv
// Request/response bundle between decode stage, ALU control and the ALU.
// Handshake: a beat transfers on a rising edge where valid && ready; the
// producer holds valid and its data stable until that edge, and ready may
// depend combinationally on the consumer side but never on valid.
interface alu_ctrl_seq_if #(
    parameter int FUNCT_W  = 5,
    parameter int ALUSEL_W = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          alu_op;
    logic [FUNCT_W-1:0]  funct;
    logic                out_valid;
    logic                out_ready;
    logic [ALUSEL_W-1:0] alu_sel;
    logic                illegal;
    logic                busy;

    modport master (
        output in_valid, alu_op, funct, out_ready,
        input  in_ready, out_valid, alu_sel, illegal, busy
    );

    modport slave (
        input  in_valid, alu_op, funct, out_ready,
        output in_ready, out_valid, alu_sel, illegal, busy
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control: decodes alu_op/funct into an ALU select code,
// flags illegal encodings and stretches MULT to MULT_LAT cycles.
module alu_ctrl_seq #(
    parameter int FUNCT_W  = 5,
    parameter int ALUSEL_W = 4,
    parameter int MULT_LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_ctrl_seq_if.slave bus,
    output logic [1:0]    dbg_state_o
);
    localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULT_LAT - 1);

    localparam logic [ALUSEL_W-1:0] SEL_AND  = ALUSEL_W'(4'b0000);
    localparam logic [ALUSEL_W-1:0] SEL_SLL  = ALUSEL_W'(4'b0001);
    localparam logic [ALUSEL_W-1:0] SEL_OR   = ALUSEL_W'(4'b0010);
    localparam logic [ALUSEL_W-1:0] SEL_XOR  = ALUSEL_W'(4'b0011);
    localparam logic [ALUSEL_W-1:0] SEL_ADD  = ALUSEL_W'(4'b0100);
    localparam logic [ALUSEL_W-1:0] SEL_ADDI = ALUSEL_W'(4'b0101);
    localparam logic [ALUSEL_W-1:0] SEL_SRL  = ALUSEL_W'(4'b0110);
    localparam logic [ALUSEL_W-1:0] SEL_MULT = ALUSEL_W'(4'b0111);
    localparam logic [ALUSEL_W-1:0] SEL_SUB  = ALUSEL_W'(4'b1100);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MULT_WAIT = 2'd1,
        HOLD      = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ALUSEL_W-1:0] sel_q, sel_d;
    logic                ill_q, ill_d;

    logic                funct_hi;
    logic [ALUSEL_W-1:0] dec_sel;
    logic                dec_ill;
    logic                dec_mult;
    logic                in_ready;
    logic                accept;

    // Funct bits above the 5-bit opcode field make any R-type request illegal.
    if (FUNCT_W > 5) begin : g_funct_hi
        assign funct_hi = |bus.funct[FUNCT_W-1:5];
    end else begin : g_no_funct_hi
        assign funct_hi = 1'b0;
    end

    always_comb begin
        dec_sel  = '0;
        dec_ill  = 1'b0;
        dec_mult = 1'b0;
        case (bus.alu_op)
            2'd0: dec_sel = SEL_ADD;
            2'd2: dec_sel = SEL_ADDI;
            2'd3: dec_sel = SEL_SUB;
            default: begin
                if (funct_hi) begin
                    dec_ill = 1'b1;
                end else begin
                    case (bus.funct[4:0])
                        5'b00001: dec_sel = SEL_AND;
                        5'b00010: dec_sel = SEL_OR;
                        5'b00011: dec_sel = SEL_XOR;
                        5'b00100: dec_sel = SEL_ADD;
                        5'b00111: dec_sel = SEL_SUB;
                        5'b01000: dec_sel = SEL_SLL;
                        5'b01001: dec_sel = SEL_SRL;
                        5'b10000: begin
                            dec_sel  = SEL_MULT;
                            dec_mult = 1'b1;
                        end
                        default:  dec_ill = 1'b1;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        ill_d    = ill_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            HOLD:    in_ready = bus.out_ready;
            default: in_ready = 1'b0;
        endcase
        if (!rst_n) begin
            in_ready = 1'b0;
        end
        accept = bus.in_valid && in_ready;

        case (state_q)
            IDLE, HOLD: begin
                if (state_q == HOLD && bus.out_ready) begin
                    state_d = IDLE;
                end
                // A take and a new accept on the same edge overwrite the result.
                if (accept) begin
                    sel_d = dec_sel;
                    ill_d = dec_ill;
                    if (dec_mult && MULT_LAT > 1) begin
                        state_d = MULT_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            MULT_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.busy      = (state_q == MULT_WAIT);
    assign bus.alu_sel   = sel_q;
    assign bus.illegal   = ill_q;
    assign dbg_state_o   = state_q;
endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, handshaked ALU control unit that generalises the single-cycle funct decoder. It decodes `alu_op`/`funct` into an ALU select code, flags illegal encodings, and holds multi-cycle MULT operations for a parametrised latency. It sits between the instruction decode stage and the ALU/multiplier, using valid/ready on both sides so the pipeline can stall.

## Interface
- `FUNCT_W`, default 5: funct field width; must be ≥5.
- `ALUSEL_W`, default 4: ALU select width; must be ≥4. Codes are zero-extended.
- `MULT_LAT`, default 4: total cycles from MULT acceptance to `out_valid`; must be ≥1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: request accepted on an edge where `in_valid && in_ready`.
- `alu_op` input 2: 0 = load/store, 1 = R-type (decode funct), 2 = ADDI, 3 = branch compare.
- `funct` input FUNCT_W: function field; used only when `alu_op == 1`.
- `out_valid` output 1: `alu_sel`/`illegal` valid for the consumer.
- `out_ready` input 1: consumer takes output on an edge where `out_valid && out_ready`.
- `alu_sel` output ALUSEL_W: registered ALU select code.
- `illegal` output 1: registered; unsupported encoding.
- `busy` output 1: high while a MULT is in progress (MULT_WAIT).

## Operation
- Decode, registered at acceptance:
  - `alu_op` 0 gives 0100 (ADD for LW/SW).
  - `alu_op` 2 gives 0101 (ADDI).
  - `alu_op` 3 gives 1100 (SUB).
  - `alu_op` 1 decodes funct: 00001 AND 0000, 00010 OR 0010, 00011 XOR 0011, 00100 ADD 0100, 00111 SUB 1100, 01000 SLL 0001, 01001 SRL 0110, 10000 MULT 0111.
- Any funct bit above bit 4 set, or any other funct value, gives `alu_sel = 0`, `illegal = 1`. Illegal requests complete with normal 1-cycle latency.
- States: IDLE, MULT_WAIT, HOLD.
- IDLE:
  - `in_ready = 1`.
  - On accept of MULT with MULT_LAT > 1, go to MULT_WAIT and load `cnt = MULT_LAT-1`.
  - On any other accept, go to HOLD.
- MULT_WAIT:
  - `in_ready = 0`, `busy = 1`, `out_valid = 0`.
  - `alu_sel` already shows 0111 and is stable.
  - `cnt` decrements each cycle; when `cnt == 0`, the next state is HOLD.
- HOLD:
  - `out_valid = 1`.
  - `in_ready = out_ready`, which gives back-to-back throughput.
  - On `out_ready` with a new accept, decode the new request with the same rules as IDLE.
  - On `out_ready` without a new accept, go to IDLE.
  - While `out_ready = 0`, `alu_sel` and `illegal` hold stable.
- `in_ready` is forced 0 while `rst_n` is low.
- `cnt` width is `$clog2(MULT_LAT)` with a minimum of 1 bit.

## Timing
- Reset (async assert, synchronous-safe deassert): state IDLE, `out_valid` 0, `alu_sel` 0, `illegal` 0, `busy` 0, `cnt` 0.
- Non-MULT or illegal request accepted at edge k: `out_valid` = 1 after edge k+1, i.e. registered, 1-cycle latency.
- MULT accepted at edge k: `busy` = 1 from k to k+MULT_LAT−1, and `out_valid` rises after edge k+MULT_LAT. With MULT_LAT = 1 this behaves the same as non-MULT.
- Sustained throughput for non-MULT ops with `out_ready` held high: 1 request per cycle.
- A request arriving while `busy` is high sees `in_ready = 0` and must hold `in_valid` and its data.
- Reset asserted mid-MULT or in HOLD: the operation is dropped, outputs go to reset values immediately, and no output is produced.
- Simultaneous output take and input accept in HOLD: the new result replaces the old one on the same edge, so no bubble is inserted.

## Test plan
- Reset, then apply `alu_op` 0, 2 and 3, one per cycle, with `out_ready` high: outputs are 0100, 0101 and 1100 on consecutive cycles, `illegal` is 0, and `in_ready` stays 1.
- `alu_op` 1 with each of the 8 legal functs back-to-back: the select code sequence matches the table, including XOR = 0011. Then funct 00101 and funct 11111 give `alu_sel` 0 and `illegal` 1 after 1 cycle.
- MULT with MULT_LAT = 4, accepted at edge k: `busy` is 1 for 4 cycles, `in_ready` is 0, `out_valid` rises after k+4 with `alu_sel` 0111. Repeat with MULT_LAT = 1: `out_valid` after k+1, and `busy` never asserts.
- Backpressure: hold `out_ready` low for 3 cycles after an AND: `out_valid` stays 1, `alu_sel` stays 0000, and `in_ready` stays 0. Release `out_ready` together with a pending OR: OR is accepted on the same edge, and 0010 appears the next cycle.
- Pull `rst_n` low 2 cycles into a MULT_LAT = 4 multiply: `busy`, `out_valid` and `alu_sel` go to 0 asynchronously. After release, the state is IDLE and no stale output appears.
- FUNCT_W = 7, ALUSEL_W = 6: funct 0000100 gives 000100, and funct 0100100 gives `illegal` 1.
